// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Branch targets are word addresses; the low two bits carry no meaning.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Request/ready handshake between the fetch stage and instruction memory.
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Small prefetch FIFO holding {pc_plus4, instruction} pairs for decode.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset; the pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; flush beats any push or pop.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC sequencing, memory handshake, prefetch
// buffering and the decode-facing instruction/PC outputs.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          branch_taken,
  input  logic [31:0]   branch_addr,
  fetch_stage_if.master imem,
  output logic          inst_valid,
  output logic [31:0]   Instraction,
  output logic [31:0]   PC
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  fetch_state_t     state;
  fetch_state_t     next_state;
  logic [31:0]      fetch_pc;
  logic [31:0]      next_pc;
  logic [31:0]      req_addr;
  logic [31:0]      pc_plus4;
  logic             issue;
  logic             req;
  logic             fifo_push;
  logic             fifo_pop;
  logic [63:0]      fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;

  assign pc_plus4 = fetch_pc + 32'd4;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (branch_taken),
    .din   ({pc_plus4, imem.imem_rdata}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // State, PC and the latched request address (held through WAIT and DROP).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= next_state;
      fetch_pc <= next_pc;
      if (issue) begin
        req_addr <= fetch_pc;
      end
    end
  end

  // Next-state logic; a branch redirects the PC from any state and wins over ready.
  always_comb begin
    next_state = state;
    next_pc    = fetch_pc;
    issue      = 1'b0;
    req        = 1'b0;
    fifo_push  = 1'b0;
    case (state)
      IDLE: begin
        if (branch_taken) begin
          next_pc = align_word(branch_addr);
        end else if (rst && (fifo_count < DEPTH_CNT)) begin
          req        = 1'b1;
          issue      = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        req = 1'b1;
        if (branch_taken) begin
          next_pc    = align_word(branch_addr);
          next_state = imem.imem_ready ? IDLE : DROP;
        end else if (imem.imem_ready) begin
          fifo_push  = 1'b1;
          next_pc    = pc_plus4;
          next_state = IDLE;
        end
      end
      DROP: begin
        req = 1'b1;
        if (branch_taken) begin
          next_pc = align_word(branch_addr);
        end
        // The stale response closes the transaction even if another branch lands with it.
        if (imem.imem_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Only one request is ever outstanding, so a push always finds a free slot.
  always_ff @(posedge clk) begin
    if (rst && fifo_push) begin
      assert (!fifo_full || fifo_pop);
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = (state == IDLE) ? fetch_pc : req_addr;

  assign fifo_pop    = !fifo_empty && !freeze && !branch_taken;
  assign inst_valid  = !fifo_empty;
  assign Instraction = fifo_empty ? NOP_INSTR : fifo_dout[31:0];
  assign PC          = fifo_empty ? 32'h0 : fifo_dout[63:32];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a variable-latency memory model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        inst_valid;
  logic [31:0] Instraction;
  logic [31:0] PC;

  int total;
  int bad;
  int lat;
  int remaining;
  logic        busy;
  logic [31:0] maddr;

  fetch_stage_if imem_bus ();

  fetch_stage #(
    .DEPTH    (2),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (imem_bus),
    .inst_valid   (inst_valid),
    .Instraction  (Instraction),
    .PC           (PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hE500_0000;
  endfunction

  // Memory responder: accepts a request mid-cycle, pulses ready 'lat' cycles later.
  always begin
    @(negedge clk);
    if (!busy && rst && imem_bus.imem_req) begin
      busy      = 1'b1;
      remaining = lat;
      maddr     = imem_bus.imem_addr;
    end
    @(posedge clk);
    #1;
    if (imem_bus.imem_ready) begin
      imem_bus.imem_ready = 1'b0;
      imem_bus.imem_rdata = 32'h0;
      busy                = 1'b0;
    end else if (busy) begin
      remaining = remaining - 1;
      if (remaining == 0) begin
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = word(maddr);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic f, input logic b,
                               input logic [31:0] ba);
    @(posedge clk);
    #1;
    rst          = r;
    freeze       = f;
    branch_taken = b;
    branch_addr  = ba;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    lat = 1;
    busy = 1'b0;
    remaining = 0;
    maddr = 32'h0;
    rst = 1'b0;
    freeze = 1'b0;
    branch_taken = 1'b0;
    branch_addr = 32'h0;
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = 32'h0;

    applyStimulus(0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("rst_req",   32'(imem_bus.imem_req), 32'd0);
    checkOutput("rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_instr", Instraction, 32'h0);
    checkOutput("rst_pc",    PC, 32'h0);

    // Startup with a 1-cycle memory: addresses 0, 4, 8 in order.
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c0_req",   32'(imem_bus.imem_req), 32'd1);
    checkOutput("c0_addr",  imem_bus.imem_addr, 32'h0);
    checkOutput("c0_valid", 32'(inst_valid), 32'd0);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c1_addr",  imem_bus.imem_addr, 32'h0);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c2_valid", 32'(inst_valid), 32'd1);
    checkOutput("c2_instr", Instraction, 32'hE500_0000);
    checkOutput("c2_pc",    PC, 32'h4);
    checkOutput("c2_addr",  imem_bus.imem_addr, 32'h4);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c3_valid", 32'(inst_valid), 32'd0);

    // Freeze for three cycles while the FIFO fills.
    applyStimulus(1, 1, 0, 32'h0);
    checkOutput("c4_addr",  imem_bus.imem_addr, 32'h8);
    checkOutput("c4_instr", Instraction, 32'hE500_0004);
    checkOutput("c4_pc",    PC, 32'h8);
    applyStimulus(1, 1, 0, 32'h0);
    checkOutput("c5_instr", Instraction, 32'hE500_0004);
    applyStimulus(1, 1, 0, 32'h0);
    checkOutput("c6_req",   32'(imem_bus.imem_req), 32'd0);
    checkOutput("c6_pc",    PC, 32'h8);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c7_req",   32'(imem_bus.imem_req), 32'd0);
    checkOutput("c7_instr", Instraction, 32'hE500_0004);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c8_instr", Instraction, 32'hE500_0008);
    checkOutput("c8_pc",    PC, 32'hC);
    checkOutput("c8_addr",  imem_bus.imem_addr, 32'hC);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c9_valid", 32'(inst_valid), 32'd0);

    // Branch from IDLE to an unaligned target; low bits are dropped.
    lat = 3;
    applyStimulus(1, 0, 1, 32'h0000_000B);
    checkOutput("c10_req",   32'(imem_bus.imem_req), 32'd0);
    checkOutput("c10_instr", Instraction, 32'hE500_000C);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c11_addr",  imem_bus.imem_addr, 32'h8);
    checkOutput("c11_valid", 32'(inst_valid), 32'd0);

    // Branch while WAIT at 8 with 3-cycle latency: DROP, then refetch at 0x40.
    applyStimulus(1, 0, 1, 32'h0000_0040);
    checkOutput("c12_addr",  imem_bus.imem_addr, 32'h8);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c13_req",   32'(imem_bus.imem_req), 32'd1);
    checkOutput("c13_addr",  imem_bus.imem_addr, 32'h8);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c14_valid", 32'(inst_valid), 32'd0);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c15_addr",  imem_bus.imem_addr, 32'h40);
    checkOutput("c15_valid", 32'(inst_valid), 32'd0);
    applyStimulus(1, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c18_valid", 32'(inst_valid), 32'd0);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c19_instr", Instraction, 32'hE500_0040);
    checkOutput("c19_pc",    PC, 32'h44);
    checkOutput("c19_addr",  imem_bus.imem_addr, 32'h44);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c20_valid", 32'(inst_valid), 32'd0);
    applyStimulus(1, 0, 0, 32'h0);

    // Branch in the same cycle as the response for 0x44.
    applyStimulus(1, 0, 1, 32'h0000_0080);
    checkOutput("c22_addr",  imem_bus.imem_addr, 32'h44);
    lat = 1;
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c23_addr",  imem_bus.imem_addr, 32'h80);
    checkOutput("c23_valid", 32'(inst_valid), 32'd0);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c24_valid", 32'(inst_valid), 32'd0);

    // PC wrap: fetch at 0xFFFF_FFFC yields PC+4 of 0.
    applyStimulus(1, 0, 1, 32'hFFFF_FFFC);
    checkOutput("c25_instr", Instraction, 32'hE500_0080);
    checkOutput("c25_pc",    PC, 32'h84);
    checkOutput("c25_req",   32'(imem_bus.imem_req), 32'd0);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c26_addr",  imem_bus.imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 32'h0);
    lat = 3;
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c28_instr", Instraction, 32'h1AFF_FFFC);
    checkOutput("c28_pc",    PC, 32'h0);
    checkOutput("c28_addr",  imem_bus.imem_addr, 32'h0);

    // Reset during WAIT; the late response must be ignored.
    applyStimulus(0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("c30_req",   32'(imem_bus.imem_req), 32'd0);
    checkOutput("c30_instr", Instraction, 32'h0);
    checkOutput("c30_pc",    PC, 32'h0);
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("c31_valid", 32'(inst_valid), 32'd0);
    lat = 1;
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c32_req",   32'(imem_bus.imem_req), 32'd1);
    checkOutput("c32_addr",  imem_bus.imem_addr, 32'h0);
    checkOutput("c32_valid", 32'(inst_valid), 32'd0);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c33_valid", 32'(inst_valid), 32'd0);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("c34_instr", Instraction, 32'hE500_0000);
    checkOutput("c34_pc",    PC, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
